// File: rtl/riscv_sc_pkg.sv
// Shared definitions for the single-cycle core's instruction memory path:
// loader state encoding, byte/word geometry and the word-aligned address shift.
package riscv_sc_pkg;

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } loader_state_e;

  localparam int HDR_BYTES       = 4;
  localparam int BYTES_PER_WORD  = 4;
  // Memory is indexed by addr[31:WORD_ADDR_SHIFT]; read and write sides share this.
  localparam int WORD_ADDR_SHIFT = 2;

  function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                 input logic [31:0] idx);
    return base + (idx << WORD_ADDR_SHIFT);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: a lane counter places each accepted byte,
// and word_valid pulses combinationally in the cycle the last byte of a word arrives.
module byte_packer
  import riscv_sc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word,
  output logic        started
);

  logic [1:0]  lane;
  logic [23:0] lower;

  // The top byte is taken straight from the bus, so only three lanes are stored.
  assign word_valid = byte_valid && (lane == 2'(BYTES_PER_WORD - 1));
  assign word       = {byte_data, lower};
  assign started    = (lane != 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane  <= 2'd0;
      lower <= 24'd0;
    end else if (byte_valid) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    lower[7:0]   <= byte_data;
        2'd1:    lower[15:8]  <= byte_data;
        2'd2:    lower[23:16] <= byte_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: reads a 4-byte word-count header, then writes
// that many little-endian words sequentially, holding the core in reset until done.
module imem_loader
  import riscv_sc_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic                       we,
  output logic [31:0]                waddr,
  output logic [31:0]                wdata,
  output logic                       cpu_rst,
  output logic                       done,
  output logic                       error,
  output logic [$clog2(DEPTH):0]     words_loaded,
  output loader_state_e              state
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  loader_state_e cur_state, nxt_state;
  logic              armed;
  logic [CNT_W-1:0]  n_words;
  logic [TO_W-1:0]   to_cnt;
  logic              accept;
  logic              word_valid;
  logic [31:0]       word;
  logic              started;
  logic              timer_on;
  logic              to_expire;
  logic              last_write;

  // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_data is
  // don't-care otherwise. in_ready never depends on in_valid.
  assign in_ready = armed && ((cur_state == ST_HDR) || (cur_state == ST_LOAD));
  assign accept   = in_valid && in_ready;
  assign done     = (cur_state == ST_DONE);
  assign error    = (cur_state == ST_ERROR);
  assign cpu_rst  = (cur_state == ST_DONE);
  assign state    = cur_state;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (accept),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word),
    .started    (started)
  );

  // The host gets unlimited time to begin; once a header byte arrives it must keep up.
  assign timer_on   = ((cur_state == ST_HDR) && started) || (cur_state == ST_LOAD);
  assign to_expire  = timer_on && !accept && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign last_write = we && ((words_loaded + CNT_W'(1)) == n_words);

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_HDR: begin
        if (to_expire)                 nxt_state = ST_ERROR;
        else if (word_valid) begin
          if (word == 32'd0)           nxt_state = ST_DONE;
          else if (word > 32'(DEPTH))  nxt_state = ST_ERROR;
          else                         nxt_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (last_write)                nxt_state = ST_DONE;
        else if (to_expire)            nxt_state = ST_ERROR;
      end
      ST_DONE:  nxt_state = ST_DONE;
      ST_ERROR: nxt_state = ST_ERROR;
      default:  nxt_state = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state    <= ST_HDR;
      armed        <= 1'b0;
      n_words      <= '0;
      to_cnt       <= '0;
      we           <= 1'b0;
      waddr        <= BASE_ADDR;
      wdata        <= 32'd0;
      words_loaded <= '0;
    end else begin
      cur_state <= nxt_state;
      armed     <= 1'b1;

      if (accept || !timer_on) to_cnt <= '0;
      else                     to_cnt <= to_cnt + TO_W'(1);

      if ((cur_state == ST_HDR) && word_valid) n_words <= word[CNT_W-1:0];

      // Write one cycle after the final byte; assembly keeps running underneath.
      we <= (cur_state == ST_LOAD) && word_valid;
      if ((cur_state == ST_LOAD) && word_valid) begin
        wdata <= word;
        waddr <= word_byte_addr(BASE_ADDR, 32'(words_loaded));
      end
      if (we) words_loaded <= words_loaded + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte-stream driver, write-port scoreboard and boundary cases
// (empty, oversize, timeouts, flow control, reset mid-load).
module tb_imem_loader;
  import riscv_sc_pkg::*;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          TO    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, we, cpu_rst, done, error;
  logic [31:0]   waddr, wdata;
  logic [10:0]   words_loaded;
  loader_state_e state;

  int n_checks = 0;
  int n_pass   = 0;
  int we_cnt   = 0;
  logic we_prev = 1'b0;
  logic [63:0] exp_q[$];

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Write-port monitor: every strobe must match the oldest expected {addr, data}.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (we) begin
      we_cnt++;
      check("we_single", {31'd0, we_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        check("we_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("waddr", waddr, e[63:32]);
        check("wdata", wdata, e[31:0]);
      end
    end
    we_prev = we;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_we"}, {31'd0, we}, 32'd0);
    check({tag, "_waddr"}, waddr, BASE);
    check({tag, "_wdata"}, wdata, 32'd0);
    check({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
    check({tag, "_state"}, 32'(state), 32'(ST_HDR));
  endtask

  // Asserts reset between clock edges and checks outputs before any edge occurs.
  task automatic apply_reset(input string tag);
    #2 rst = 1'b0;
    #1 check_reset_outputs(tag);
    exp_q.delete();
    idle(2);
    rst = 1'b1;
    idle(1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("ready_wait", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (gap_max > 0 && $urandom_range(0, 2) != 0) idle($urandom_range(1, gap_max));
    end
  endtask

  task automatic load_word(input int idx, input logic [31:0] w, input int gap_max);
    exp_q.push_back({BASE + 32'(idx) * 32'd4, w});
    send_word(w, gap_max);
  endtask

  task automatic wait_end(input string tag, input logic want_done);
    int n = 0;
    while (!(done || error) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'd0, done}, {31'd0, want_done});
    check({tag, "_error"}, {31'd0, error}, {31'd0, !want_done});
  endtask

  initial begin
    int base_we;
    logic [31:0] w;

    apply_reset("rst0");

    // Host silent for a long time before the header: must not time out.
    idle(100);
    check("pre_hdr_error", {31'd0, error}, 32'd0);
    check("pre_hdr_ready", {31'd0, in_ready}, 32'd1);

    // Basic two-word load.
    base_we = we_cnt;
    send_word(32'd2, 0);
    load_word(0, 32'h0000_0513, 0);
    load_word(1, 32'h0010_0093, 0);
    wait_end("basic", 1'b1);
    idle(2);
    check("basic_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("basic_words", 32'(words_loaded), 32'd2);
    check("basic_in_ready", {31'd0, in_ready}, 32'd0);
    check("basic_we_cnt", 32'(we_cnt - base_we), 32'd2);
    check("basic_waddr_hold", waddr, 32'h4);
    check("basic_wdata_hold", wdata, 32'h0010_0093);
    check("basic_q_empty", 32'(exp_q.size()), 32'd0);

    // Empty image.
    apply_reset("rst1");
    base_we = we_cnt;
    send_word(32'd0, 0);
    wait_end("empty", 1'b1);
    idle(3);
    check("empty_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("empty_we_cnt", 32'(we_cnt - base_we), 32'd0);
    check("empty_words", 32'(words_loaded), 32'd0);

    // Oversize image.
    apply_reset("rst2");
    base_we = we_cnt;
    send_word(32'd1025, 0);
    wait_end("over", 1'b0);
    idle(3);
    check("over_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("over_in_ready", {31'd0, in_ready}, 32'd0);
    check("over_we_cnt", 32'(we_cnt - base_we), 32'd0);

    // Exactly DEPTH words is legal: loader must enter LOAD.
    apply_reset("rst3");
    send_word(32'd1024, 0);
    idle(2);
    check("max_state", 32'(state), 32'(ST_LOAD));
    check("max_error", {31'd0, error}, 32'd0);
    check("max_in_ready", {31'd0, in_ready}, 32'd1);

    // Timeout mid-word in LOAD.
    apply_reset("rst4");
    base_we = we_cnt;
    send_word(32'd1, 0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle(14);
    check("to_early_error", {31'd0, error}, 32'd0);
    idle(3);
    check("to_error", {31'd0, error}, 32'd1);
    check("to_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("to_in_ready", {31'd0, in_ready}, 32'd0);
    check("to_we_cnt", 32'(we_cnt - base_we), 32'd0);
    check("to_done", {31'd0, done}, 32'd0);

    // Timeout inside the header after its first byte.
    apply_reset("rst5");
    send_byte(8'h01);
    idle(20);
    check("hdr_to_error", {31'd0, error}, 32'd1);

    // Flow control: eight random words with gaps and back-to-back bursts.
    apply_reset("rst6");
    base_we = we_cnt;
    send_word(32'd8, 3);
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      load_word(i, w, 5);
    end
    wait_end("flow", 1'b1);
    idle(2);
    check("flow_we_cnt", 32'(we_cnt - base_we), 32'd8);
    check("flow_words", 32'(words_loaded), 32'd8);
    check("flow_waddr_last", waddr, 32'h1C);
    check("flow_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a load, then a fresh one-word load.
    apply_reset("rst7");
    send_word(32'd4, 0);
    load_word(0, 32'hDEAD_BEEF, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    check("mid_words", 32'(words_loaded), 32'd1);
    apply_reset("rst_mid");
    base_we = we_cnt;
    send_word(32'd1, 0);
    load_word(0, 32'hCAFE_F00D, 1);
    wait_end("reload", 1'b1);
    idle(2);
    check("reload_we_cnt", 32'(we_cnt - base_we), 32'd1);
    check("reload_waddr", waddr, BASE);
    check("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("reload_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
